// File: rtl/io_read_fifo_port.sv
// Read-side I/O port: a small FIFO filled by an external producer and drained by CPU IN cycles.
// Optional registered interrupt output enabled by defining IO_READ_FIFO_IRQ_EN.
module io_read_fifo_port #(
    parameter int unsigned  N           = 8,
    parameter int unsigned  DEPTH       = 4,
    parameter logic [N-1:0] EMPTY_VALUE = N'(8'hFF)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         ext_strobe,
    input  logic [N-1:0] ext_data,
    output logic         ext_ready,
    input  logic         cpu_rd,
    input  logic         cpu_sel,
    output logic [N-1:0] cpu_data
`ifdef IO_READ_FIFO_IRQ_EN
    ,
    output logic         irq
`endif
);

    localparam int unsigned  AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]  FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]  COUNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    logic [N-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overrun;
    logic [N-1:0]  r_cpu_data;
    logic          r_rd_active;
    logic          r_sel_q;
    logic          r_rd_nonempty;
    logic          r_strobe_prev;
    logic          r_rd_prev;

    logic          w_push_ev;
    logic          w_rd_rise;
    logic          w_rd_fall;
    logic          w_full;
    logic          w_empty;
    logic          w_do_push;
    logic          w_do_pop;
    logic          w_overrun_ev;
    logic [AW:0]   w_count_next;
    logic [N-1:0]  w_status;

    assign w_push_ev    = ext_strobe & ~r_strobe_prev;
    assign w_rd_rise    = cpu_rd & ~r_rd_prev;
    assign w_rd_fall    = ~cpu_rd & r_rd_prev & r_rd_active;
    assign w_full       = (r_count == FULL_COUNT);
    assign w_empty      = (r_count == '0);
    // Full is judged on the pre-pop count, so a push into a full FIFO is lost even if a pop coincides.
    assign w_do_push    = w_push_ev & ~w_full;
    assign w_overrun_ev = w_push_ev & w_full;
    assign w_do_pop     = w_rd_fall & ~r_sel_q & r_rd_nonempty;

    assign ext_ready = ~w_full;
    assign cpu_data  = r_cpu_data;

    always_comb begin
        w_count_next = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_next = r_count + COUNT_ONE;
        end else if (!w_do_push && w_do_pop) begin
            w_count_next = r_count - COUNT_ONE;
        end
    end

    always_comb begin
        w_status    = '0;
        w_status[0] = ~w_empty;
        w_status[1] = w_full;
        w_status[2] = r_overrun;
    end

`ifdef IO_READ_FIFO_IRQ_EN
    logic w_rd_active_next;
    logic r_irq;

    assign w_rd_active_next = w_rd_rise ? 1'b1 : (w_rd_fall ? 1'b0 : r_rd_active);
    assign irq              = r_irq;
`endif

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= ext_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_overrun     <= 1'b0;
            r_cpu_data    <= '0;
            r_rd_active   <= 1'b0;
            r_sel_q       <= 1'b0;
            r_rd_nonempty <= 1'b0;
            // Held-high strobes across reset release must not look like fresh edges.
            r_strobe_prev <= 1'b1;
            r_rd_prev     <= 1'b1;
`ifdef IO_READ_FIFO_IRQ_EN
            r_irq         <= 1'b0;
`endif
        end else begin
            r_strobe_prev <= ext_strobe;
            r_rd_prev     <= cpu_rd;
            r_count       <= w_count_next;
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_overrun_ev) begin
                r_overrun <= 1'b1;
            end else if (w_rd_fall && r_sel_q) begin
                r_overrun <= 1'b0;
            end
            if (w_rd_rise) begin
                r_rd_active   <= 1'b1;
                r_sel_q       <= cpu_sel;
                r_rd_nonempty <= ~w_empty;
                if (cpu_sel) begin
                    r_cpu_data <= w_status;
                end else if (w_empty) begin
                    r_cpu_data <= EMPTY_VALUE;
                end else begin
                    r_cpu_data <= r_mem[r_rd_ptr];
                end
            end else if (w_rd_fall) begin
                r_rd_active <= 1'b0;
            end
`ifdef IO_READ_FIFO_IRQ_EN
            r_irq <= (w_count_next != '0) & ~w_rd_active_next;
`endif
        end
    end

endmodule

// File: tb/tb_io_read_fifo_port.sv
// Scoreboard bench for io_read_fifo_port: reads queue their expected word, a monitor checks each capture.
// Build with IO_READ_FIFO_IRQ_EN defined to also exercise the irq output.
module tb_io_read_fifo_port;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ext_strobe = 1'b0;
    logic [7:0] ext_data = 8'h00;
    logic       ext_ready;
    logic       cpu_rd = 1'b0;
    logic       cpu_sel = 1'b0;
    logic [7:0] cpu_data;
`ifdef IO_READ_FIFO_IRQ_EN
    logic       irq;
`endif

    int         compared = 0;
    int         mismatched = 0;
    logic [7:0] expQ[$];
    logic       tbRdPrev = 1'b1;
    logic       readCaptured = 1'b0;

    io_read_fifo_port #(.N(8), .DEPTH(4), .EMPTY_VALUE(8'hFF)) dut (
        .clock     (clock),
        .reset     (reset),
        .ext_strobe(ext_strobe),
        .ext_data  (ext_data),
        .ext_ready (ext_ready),
        .cpu_rd    (cpu_rd),
        .cpu_sel   (cpu_sel),
        .cpu_data  (cpu_data)
`ifdef IO_READ_FIFO_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, actual, expected);
        end
    endtask

    // Tracks rising edges of the bench's own read strobe, so the capture cycle is known independently.
    always @(posedge clock) begin
        readCaptured <= !reset && cpu_rd && !tbRdPrev;
        tbRdPrev     <= reset ? 1'b1 : cpu_rd;
    end

    always @(negedge clock) begin
        if (readCaptured) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpectedRead: got 0x%02h, expected no read", cpu_data);
            end else begin
                checkOutput("readData", cpu_data, expQ.pop_front());
            end
        end
    end

    task automatic pushWord(input logic [7:0] d);
        @(negedge clock);
        ext_data   = d;
        ext_strobe = 1'b1;
        @(negedge clock);
        ext_strobe = 1'b0;
    endtask

    task automatic applyStimulus(input logic sel, input int holdCycles, input logic [7:0] expected);
        expQ.push_back(expected);
        @(negedge clock);
        cpu_sel = sel;
        cpu_rd  = 1'b1;
        repeat (holdCycles) @(negedge clock);
        cpu_rd = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        checkOutput("resetCpuData", cpu_data, 8'h00);
        checkOutput("resetReady", {7'd0, ext_ready}, 8'h01);
`ifdef IO_READ_FIFO_IRQ_EN
        checkOutput("resetIrq", {7'd0, irq}, 8'h00);
`endif

        applyStimulus(1'b1, 3, 8'h00);
        checkOutput("readyAfterStatus", {7'd0, ext_ready}, 8'h01);

        pushWord(8'h41);
        pushWord(8'h42);
        applyStimulus(1'b0, 2, 8'h41);
        applyStimulus(1'b0, 2, 8'h42);
        applyStimulus(1'b0, 2, 8'hFF);
        applyStimulus(1'b1, 1, 8'h00);

        for (int i = 0; i < 5; i++) begin
            pushWord(8'h10 + 8'(i));
            if (i == 2) checkOutput("readyAtThree", {7'd0, ext_ready}, 8'h01);
            if (i == 3) checkOutput("readyAtFull", {7'd0, ext_ready}, 8'h00);
        end
        applyStimulus(1'b1, 2, 8'h07);
        applyStimulus(1'b1, 2, 8'h03);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 2, 8'h10 + 8'(i));
        applyStimulus(1'b1, 1, 8'h00);

        pushWord(8'h20);
        pushWord(8'h21);
        pushWord(8'h22);
        expQ.push_back(8'h20);
        @(negedge clock);
        cpu_sel = 1'b0;
        cpu_rd  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (c == 3) begin
                ext_data   = 8'h23;
                ext_strobe = 1'b1;
            end
            if (c == 4) ext_strobe = 1'b0;
        end
        checkOutput("heldReadStable", cpu_data, 8'h20);
        cpu_rd = 1'b0;
        @(negedge clock);
        checkOutput("readyAfterLongRead", {7'd0, ext_ready}, 8'h01);
        applyStimulus(1'b0, 2, 8'h21);

        expQ.push_back(8'h22);
        @(negedge clock);
        cpu_sel = 1'b0;
        cpu_rd  = 1'b1;
        @(negedge clock);
        @(negedge clock);
        cpu_rd     = 1'b0;
        ext_data   = 8'h24;
        ext_strobe = 1'b1;
        @(negedge clock);
        ext_strobe = 1'b0;
        applyStimulus(1'b1, 1, 8'h01);
        applyStimulus(1'b0, 2, 8'h23);
        applyStimulus(1'b0, 2, 8'h24);
        applyStimulus(1'b0, 2, 8'hFF);

        pushWord(8'h30);
        expQ.push_back(8'h30);
        @(negedge clock);
        cpu_sel = 1'b0;
        cpu_rd  = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        checkOutput("cpuDataAfterReset", cpu_data, 8'h00);
        pushWord(8'h31);
        @(negedge clock);
        cpu_rd = 1'b0;
        @(negedge clock);
        checkOutput("cpuDataAfterStaleFall", cpu_data, 8'h00);
        applyStimulus(1'b0, 2, 8'h31);
        applyStimulus(1'b0, 2, 8'hFF);

`ifdef IO_READ_FIFO_IRQ_EN
        pushWord(8'h55);
        checkOutput("irqAfterPush", {7'd0, irq}, 8'h01);
        expQ.push_back(8'h55);
        @(negedge clock);
        cpu_sel = 1'b0;
        cpu_rd  = 1'b1;
        @(negedge clock);
        checkOutput("irqDuringRead", {7'd0, irq}, 8'h00);
        cpu_rd = 1'b0;
        @(negedge clock);
        checkOutput("irqAfterEmptyingRead", {7'd0, irq}, 8'h00);
        @(negedge clock);
        checkOutput("irqStaysLow", {7'd0, irq}, 8'h00);
`endif

        repeat (2) @(negedge clock);
        checkOutput("queueDrained", 8'(expQ.size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
